// File: rtl/table_pkg.sv
// Shared types and sizing helpers for the init-then-round-robin table writer.
package table_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEPTH_DEF = 5;
  localparam int WIDTH_DEF = 5;
  localparam int NREQ_DEF  = 2;

  // clog2 clamped to at least one bit so single-entry indices stay legal vectors.
  function automatic int addr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
  import table_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int PW   = addr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    int   j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/table_init_rr_writer.sv
// Register table loaded with its index pattern after reset, then written by
// NREQ requesters through a round-robin valid/ready arbiter.
module table_init_rr_writer
  import table_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int AW    = addr_width(DEPTH),
  localparam int PW    = addr_width(NREQ)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         reinit,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*AW-1:0]           req_addr,
  input  logic [NREQ*WIDTH-1:0]        req_data,
  output logic [DEPTH-1:0][WIDTH-1:0]  O,
  output logic                         init_done,
  output logic                         addr_err
);

  state_t            state, state_nxt;
  logic [AW-1:0]     idx;
  logic [PW-1:0]     rr_ptr;
  logic [NREQ-1:0]   arb_grant;
  logic [PW-1:0]     arb_idx;
  logic              hs;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              addr_ok;
  logic              last_idx;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign last_idx = (idx == AW'(DEPTH - 1));
  assign sel_addr = req_addr[int'(arb_idx) * AW +: AW];
  assign sel_data = req_data[int'(arb_idx) * WIDTH +: WIDTH];
  assign addr_ok  = ({1'b0, sel_addr} < (AW + 1)'(DEPTH));
  assign hs       = |req_ready;

  always_comb begin
    state_nxt = state;
    if (reinit)
      state_nxt = INIT;
    else if (state == INIT && last_idx)
      state_nxt = RUN;
  end

  // Grants are suppressed outside RUN and whenever a restart or reset is pending.
  always_comb begin
    req_ready = '0;
    if (state == RUN && !reinit && !RESET)
      req_ready = arb_grant;
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state     <= INIT;
      idx       <= '0;
      rr_ptr    <= '0;
      init_done <= 1'b0;
      addr_err  <= 1'b0;
      // NOTE: the table is plain flops, not a RAM macro, so clearing it in reset is cheap and legal.
      O         <= '0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RUN);
      addr_err  <= hs && !addr_ok;
      if (reinit) begin
        idx <= '0;
      end else if (state == INIT) begin
        for (int i = 0; i < DEPTH; i++)
          if (idx == AW'(i)) O[i] <= WIDTH'(i);
        idx <= last_idx ? '0 : idx + AW'(1);
      end
      // Sweep and requester writes never overlap: hs is only possible in RUN.
      if (hs) begin
        rr_ptr <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
        if (addr_ok)
          for (int i = 0; i < DEPTH; i++)
            if (sel_addr == AW'(i)) O[i] <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_table_init_rr_writer.sv
// Directed bench for table_init_rr_writer with a cycle-level behavioural model.
module tb_table_init_rr_writer;

  localparam int DEPTH = 5;
  localparam int WIDTH = 5;
  localparam int NREQ  = 2;
  localparam int AW    = 3;

  logic                        CLK = 1'b0;
  logic                        RESET;
  logic                        reinit;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*AW-1:0]          req_addr;
  logic [NREQ*WIDTH-1:0]       req_data;
  logic [DEPTH-1:0][WIDTH-1:0] O;
  logic                        init_done;
  logic                        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  table_init_rr_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .reinit    (reinit),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .O         (O),
    .init_done (init_done),
    .addr_err  (addr_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model: table contents, whether the sweep has finished, next sweep slot, rotation pointer.
  int m_tab[DEPTH] = '{default: 0};
  bit m_run = 1'b0;
  int m_idx = 0;
  int m_ptr = 0;
  bit m_err = 1'b0;

  always @(negedge CLK) begin
    int                     g;
    int                     a;
    logic [NREQ-1:0]        er;
    logic [DEPTH*WIDTH-1:0] ev;
    g  = -1;
    er = '0;
    if (m_run && !reinit && !RESET)
      for (int s = 0; s < NREQ; s++)
        if (g < 0 && req_valid[(m_ptr + s) % NREQ]) g = (m_ptr + s) % NREQ;
    if (g >= 0) er[g] = 1'b1;
    for (int i = 0; i < DEPTH; i++) ev[i*WIDTH +: WIDTH] = WIDTH'(m_tab[i]);

    check("model_ready", req_ready, er);
    check("model_table", O, ev);
    check("model_init_done", init_done, m_run);
    check("model_addr_err", addr_err, m_err);

    m_err = 1'b0;
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
      m_run = 1'b0;
      m_idx = 0;
      m_ptr = 0;
    end else if (reinit) begin
      m_run = 1'b0;
      m_idx = 0;
    end else if (!m_run) begin
      m_tab[m_idx] = m_idx % (1 << WIDTH);
      if (m_idx == DEPTH - 1) begin
        m_run = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (g >= 0) begin
      a = int'(req_addr[g*AW +: AW]);
      if (a < DEPTH) m_tab[a] = int'(req_data[g*WIDTH +: WIDTH]);
      else m_err = 1'b1;
      m_ptr = (g + 1) % NREQ;
    end
  end

  logic [NREQ-1:0] grants[4];

  initial begin
    RESET     = 1'b1;
    reinit    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();

    // Reset release with both requesters already asserting.
    RESET     = 1'b0;
    req_valid = 2'b11;
    req_addr  = {3'd1, 3'd0};
    req_data  = {5'd17, 5'd31};
    #1 check("reset_table_zero", O, '0);
    for (int i = 0; i < DEPTH; i++) begin
      #1 check("sweep_ready_zero", req_ready, 2'b00);
      tick();
    end
    #1 check("sweep_table", O, {5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
    check("sweep_done", init_done, 1'b1);

    // Round robin with continuous contention.
    for (int i = 0; i < 4; i++) begin
      #1 grants[i] = req_ready;
      tick();
    end
    check("rr_grant0", grants[0], 2'b01);
    check("rr_grant1", grants[1], 2'b10);
    check("rr_grant2", grants[2], 2'b01);
    check("rr_grant3", grants[3], 2'b10);
    check("rr_table", O, {5'd4, 5'd3, 5'd2, 5'd17, 5'd31});

    // Single requester keeps winning, then the other one alone.
    req_valid = 2'b10;
    req_addr  = {3'd4, 3'd0};
    req_data  = {5'd9, 5'd31};
    for (int i = 0; i < 3; i++) begin
      #1 check("single_ready1", req_ready, 2'b10);
      tick();
    end
    check("single_table", O, {5'd9, 5'd3, 5'd2, 5'd17, 5'd31});
    req_valid = 2'b01;
    req_data  = {5'd9, 5'd12};
    #1 check("single_ready0", req_ready, 2'b01);
    tick();
    check("single_table0", O, {5'd9, 5'd3, 5'd2, 5'd17, 5'd12});

    // Out-of-range address: accepted, table untouched, one-cycle error pulse.
    req_addr  = {3'd4, 3'd6};
    req_data  = {5'd9, 5'd5};
    #1 check("bad_addr_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1 check("bad_addr_err", addr_err, 1'b1);
    check("bad_addr_table", O, {5'd9, 5'd3, 5'd2, 5'd17, 5'd12});
    tick();
    check("bad_addr_err_clear", addr_err, 1'b0);

    // Reinit under contention.
    req_valid = 2'b11;
    req_addr  = {3'd1, 3'd0};
    req_data  = {5'd17, 5'd31};
    reinit    = 1'b1;
    #1 check("reinit_no_grant", req_ready, 2'b00);
    tick();
    reinit = 1'b0;
    check("reinit_done_low", init_done, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      #1 check("resweep_ready_zero", req_ready, 2'b00);
      tick();
    end
    check("resweep_table", O, {5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
    check("resweep_done", init_done, 1'b1);
    #1 check("resweep_grant_resume", req_ready, 2'b10);
    tick();

    // Reset in the middle of a sweep.
    req_valid = 2'b00;
    reinit    = 1'b1;
    tick();
    reinit = 1'b0;
    tick();
    tick();
    check("midsweep_done_low", init_done, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midreset_table", O, '0);
    check("midreset_done", init_done, 1'b0);
    tick();
    tick();
    check("midreset_partial", O, {5'd0, 5'd0, 5'd0, 5'd1, 5'd0});
    check("midreset_partial_done", init_done, 1'b0);
    tick();
    tick();
    tick();
    check("midreset_final", O, {5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
    check("midreset_final_done", init_done, 1'b1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
